busca_instrucao: RTL and testbench

Instruction-fetch stage of the multicycle datapath. Holds the program counter (PC) and the instruction register (IR), and runs the instruction-memory read handshake. Decodes the IR into fields; its 4-bit opcode is the input to the control unit. Consumes that unit's EscIR, EscCP, EscCondCP and FonteCP strobes to fetch instructions and update the PC.

---
 rtl/busca_instrucao.sv | 201 ++++++++++++++++++++
 tb/tb_busca_instrucao.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// ---------------------------------------------------------------------------
// busca_instrucao -- instruction-fetch stage of the multicycle datapath.
//
// Holds the program counter and the instruction register. Runs the read
// handshake with instruction memory and slices the IR into decode fields.
// The PC is updated every cycle from the control-unit strobes. This update
// does not depend on the fetch FSM.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   esc_ir           fetch request (EscIR), accepted only when idle
//   esc_cp           unconditional PC write (EscCP)
//   esc_cond_cp      PC write qualified by zero (EscCondCP)
//   fonte_cp         PC source: 0 = pc + 1, 1 = pc_alvo (FonteCP)
//   zero             ALU zero flag
//   pc_alvo          branch/jump target
//   mem_req/addr     registered memory read request and address
//   mem_ack/rdata    read-data-valid strobe and instruction word
//   ir               instruction register
//   opcode .. endereco  combinational slices of ir
//   pc               current program counter
//   ir_valido        one-cycle pulse when ir holds a newly fetched word
//   ocupado          high whenever the fetch FSM is not idle
//   erro_busca       sticky fetch-timeout flag (only with BUSCA_TIMEOUT_EN)
//
// Build option: define BUSCA_TIMEOUT_EN to abort a fetch after
// TIMEOUT_CICLOS cycles in BUSCA without an ack. The aborted fetch loads a
// NOP and raises erro_busca.
// ---------------------------------------------------------------------------
module busca_instrucao #(
    parameter int unsigned LARG_PC        = 12,
    parameter int unsigned PC_INICIAL     = 0,
    parameter int unsigned TIMEOUT_CICLOS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               esc_ir,
    input  logic               esc_cp,
    input  logic               esc_cond_cp,
    input  logic               fonte_cp,
    input  logic               zero,
    input  logic [LARG_PC-1:0] pc_alvo,
    output logic               mem_req,
    output logic [LARG_PC-1:0] mem_addr,
    input  logic               mem_ack,
    input  logic [15:0]        mem_rdata,
    output logic [15:0]        ir,
    output logic [3:0]         opcode,
    output logic [3:0]         campo_rd,
    output logic [3:0]         campo_rs,
    output logic [3:0]         campo_rt,
    output logic [7:0]         imediato,
    output logic [11:0]        endereco,
    output logic [LARG_PC-1:0] pc,
    output logic               ir_valido,
    output logic               ocupado
`ifdef BUSCA_TIMEOUT_EN
    ,
    output logic               erro_busca
`endif
);

    if (TIMEOUT_CICLOS == 0) begin : g_cfg_invalid
        $error("busca_instrucao: TIMEOUT_CICLOS must be at least 1");
    end

    typedef enum logic [1:0] {
        OCIOSO,
        BUSCA,
        ENTREGA
    } estado_t;

    estado_t            estado, estado_prox;
    logic               mem_req_prox;
    logic [LARG_PC-1:0] mem_addr_prox;
    logic [15:0]        ir_prox;
    logic               ir_valido_prox;
    logic               pc_wr;
    logic [LARG_PC-1:0] pc_prox;

`ifdef BUSCA_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    logic [CNT_W-1:0] cnt, cnt_prox;
    logic             erro_prox;
`endif

    // ------------------------------------------------------------------
    // Decode fields
    // ------------------------------------------------------------------
    assign opcode   = ir[15:12];
    assign campo_rd = ir[11:8];
    assign campo_rs = ir[7:4];
    assign campo_rt = ir[3:0];
    assign imediato = ir[7:0];
    assign endereco = ir[11:0];

    assign ocupado  = (estado != OCIOSO);

    // ------------------------------------------------------------------
    // PC update (independent of the fetch FSM; pc + 1 wraps naturally)
    // ------------------------------------------------------------------
    assign pc_wr = esc_cp | (esc_cond_cp & zero);

    always_comb begin
        pc_prox = pc;
        if (pc_wr) begin
            pc_prox = fonte_cp ? pc_alvo : pc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        estado_prox    = estado;
        mem_req_prox   = mem_req;
        mem_addr_prox  = mem_addr;
        ir_prox        = ir;
        ir_valido_prox = 1'b0;
`ifdef BUSCA_TIMEOUT_EN
        cnt_prox       = cnt;
        erro_prox      = erro_busca;
`endif
        unique case (estado)
            OCIOSO: begin
                if (esc_ir) begin
                    // Captures the PC before any write in this same cycle.
                    mem_addr_prox = pc;
                    mem_req_prox  = 1'b1;
                    estado_prox   = BUSCA;
`ifdef BUSCA_TIMEOUT_EN
                    cnt_prox      = '0;
`endif
                end
            end
            BUSCA: begin
                if (mem_ack) begin
                    ir_prox        = mem_rdata;
                    mem_req_prox   = 1'b0;
                    ir_valido_prox = 1'b1;
                    estado_prox    = ENTREGA;
                end
`ifdef BUSCA_TIMEOUT_EN
                // cnt counts the earlier BUSCA cycles that had no ack. The
                // limit is reached on the TIMEOUT_CICLOS-th such cycle. An
                // ack in that same cycle still takes priority.
                else if (cnt == CNT_W'(TIMEOUT_CICLOS - 1)) begin
                    ir_prox        = '0;
                    mem_req_prox   = 1'b0;
                    ir_valido_prox = 1'b1;
                    erro_prox      = 1'b1;
                    estado_prox    = ENTREGA;
                end else begin
                    cnt_prox = cnt + 1'b1;
                end
`endif
            end
            ENTREGA: begin
                estado_prox = OCIOSO;
            end
            default: begin
                estado_prox  = OCIOSO;
                mem_req_prox = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            pc        <= LARG_PC'(PC_INICIAL);
            ir        <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            ir_valido <= 1'b0;
        end else begin
            estado    <= estado_prox;
            pc        <= pc_prox;
            ir        <= ir_prox;
            mem_req   <= mem_req_prox;
            mem_addr  <= mem_addr_prox;
            ir_valido <= ir_valido_prox;
        end
    end

`ifdef BUSCA_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            erro_busca <= 1'b0;
        end else begin
            cnt        <= cnt_prox;
            erro_busca <= erro_prox;
        end
    end
`endif

endmodule

// File: tb/tb_busca_instrucao.sv
// ---------------------------------------------------------------------------
// tb_busca_instrucao -- self-checking bench for busca_instrucao.
// The PC reference is an integer model updated from the strobe rules each
// clock. Fetch expectations are transaction-level: each fetch has one
// captured address and one word, with fixed pulse timing.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_busca_instrucao;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        esc_ir, esc_cp, esc_cond_cp, fonte_cp, zero;
    logic [11:0] pc_alvo;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] ir;
    logic [3:0]  opcode, campo_rd, campo_rs, campo_rt;
    logic [7:0]  imediato;
    logic [11:0] endereco;
    logic [11:0] pc;
    logic        ir_valido, ocupado;
`ifdef BUSCA_TIMEOUT_EN
    logic        erro_busca;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned pcm;   // reference program counter

    busca_instrucao #(
        .LARG_PC(12),
        .PC_INICIAL(0),
        .TIMEOUT_CICLOS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .esc_ir(esc_ir), .esc_cp(esc_cp), .esc_cond_cp(esc_cond_cp),
        .fonte_cp(fonte_cp), .zero(zero), .pc_alvo(pc_alvo),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .opcode(opcode), .campo_rd(campo_rd), .campo_rs(campo_rs),
        .campo_rt(campo_rt), .imediato(imediato), .endereco(endereco),
        .pc(pc), .ir_valido(ir_valido), .ocupado(ocupado)
`ifdef BUSCA_TIMEOUT_EN
        , .erro_busca(erro_busca)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock edge, applying the PC rule to the reference model.
    task automatic tick();
        if (esc_cp || (esc_cond_cp && zero))
            pcm = fonte_cp ? int'(pc_alvo) : (pcm + 1) % 4096;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        esc_ir = 0; esc_cp = 0; esc_cond_cp = 0; fonte_cp = 0; zero = 0;
        mem_ack = 0;
    endtask

    task automatic set_pc(input logic [11:0] v);
        esc_cp = 1; fonte_cp = 1; pc_alvo = v;
        tick();
        esc_cp = 0; fonte_cp = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        pcm = 0;
        #7;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        pc_alvo = '0; mem_rdata = '0;
        rst_n = 0;
        pcm = 0;
        #12;
        n_checks++; if (pc !== 12'h000) $display("FAIL reset_pc: got %h want 000", pc); else n_pass++;
        n_checks++; if (ir !== 16'h0000 || opcode !== 4'h0) $display("FAIL reset_ir: got %h/%h want 0000/0", ir, opcode); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || mem_addr !== 12'h000) $display("FAIL reset_mem: got req=%b addr=%h want 0/000", mem_req, mem_addr); else n_pass++;
        n_checks++; if (ir_valido !== 1'b0 || ocupado !== 1'b0) $display("FAIL reset_flags: got valid=%b busy=%b want 0/0", ir_valido, ocupado); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        set_pc(12'h005);
        esc_ir = 1;
        tick();
        esc_ir = 0;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h005) $display("FAIL zw_req: got req=%b addr=%h want 1/005", mem_req, mem_addr); else n_pass++;
        n_checks++; if (ocupado !== 1'b1) $display("FAIL zw_busy: got %b want 1", ocupado); else n_pass++;
        mem_ack = 1; mem_rdata = 16'hB123;
        tick();
        mem_ack = 0;
        n_checks++; if (ir !== 16'hB123) $display("FAIL zw_ir: got %h want b123", ir); else n_pass++;
        n_checks++; if (opcode !== 4'hB || endereco !== 12'h123) $display("FAIL zw_fields: got op=%h end=%h want b/123", opcode, endereco); else n_pass++;
        n_checks++; if (ir_valido !== 1'b1 || mem_req !== 1'b0) $display("FAIL zw_pulse: got valid=%b req=%b want 1/0", ir_valido, mem_req); else n_pass++;
        tick();
        n_checks++; if (ir_valido !== 1'b0) $display("FAIL zw_pulse_end: got %b want 0", ir_valido); else n_pass++;
        tick();
        n_checks++; if (ocupado !== 1'b0) $display("FAIL zw_idle: got %b want 0", ocupado); else n_pass++;
    endtask

    task automatic test_waited_fetch();
        set_pc(12'h005);
        esc_ir = 1; esc_cp = 1; fonte_cp = 0;
        tick();
        esc_ir = 0; esc_cp = 0;
        n_checks++; if (mem_addr !== 12'h005) $display("FAIL wf_addr: got %h want 005", mem_addr); else n_pass++;
        n_checks++; if (pc !== 12'h006) $display("FAIL wf_pc: got %h want 006", pc); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            esc_ir = (i == 1);
            tick();
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h005 || ir_valido !== 1'b0) $display("FAIL wf_hold%0d: got req=%b addr=%h valid=%b want 1/005/0", i, mem_req, mem_addr, ir_valido); else n_pass++;
        end
        esc_ir = 0;
        mem_ack = 1; mem_rdata = 16'h3C5A;
        tick();
        mem_ack = 0;
        n_checks++; if (ir !== 16'h3C5A || ir_valido !== 1'b1) $display("FAIL wf_ir: got %h valid=%b want 3c5a/1", ir, ir_valido); else n_pass++;
        tick();
        tick();
        // The esc_ir raised during BUSCA must not have been queued.
        n_checks++; if (mem_req !== 1'b0 || ocupado !== 1'b0) $display("FAIL wf_noqueue: got req=%b busy=%b want 0/0", mem_req, ocupado); else n_pass++;
    endtask

    task automatic test_cond_branch();
        set_pc(12'h010);
        esc_cond_cp = 1; fonte_cp = 1; pc_alvo = 12'h0A0; zero = 0;
        tick();
        n_checks++; if (pc !== 12'h010) $display("FAIL cb_zero0: got %h want 010", pc); else n_pass++;
        zero = 1;
        tick();
        n_checks++; if (pc !== 12'h0A0) $display("FAIL cb_zero1: got %h want 0a0", pc); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_wrap();
        set_pc(12'hFFF);
        esc_cp = 1; fonte_cp = 0;
        tick();
        esc_cp = 0;
        n_checks++; if (pc !== 12'h000) $display("FAIL wrap: got %h want 000", pc); else n_pass++;
    endtask

    task automatic test_random_pc();
        for (int i = 0; i < 150; i++) begin
            esc_cp      = 1'($urandom_range(0, 3) == 0);
            esc_cond_cp = 1'($urandom_range(0, 1));
            zero        = 1'($urandom_range(0, 1));
            fonte_cp    = 1'($urandom_range(0, 1));
            pc_alvo     = 12'($urandom);
            if (i % 40 == 0) begin
                pc_alvo = 12'hFFF; fonte_cp = 1; esc_cp = 1;
            end
            tick();
            n_checks++; if (pc !== 12'(pcm)) $display("FAIL rnd_pc%0d: got %h want %h", i, pc, 12'(pcm)); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_random_fetch();
        logic [11:0] a;
        logic [15:0] d;
        int unsigned w;
        for (int t = 0; t < 20; t++) begin
            a = 12'($urandom);
            d = 16'($urandom);
            w = $urandom_range(0, 5);
            set_pc(a);
            esc_ir = 1;
            esc_cp = 1'($urandom_range(0, 1)); fonte_cp = 1'($urandom_range(0, 1));
            pc_alvo = 12'($urandom);
            tick();
            n_checks++; if (mem_req !== 1'b1 || mem_addr !== a) $display("FAIL rf_req%0d: got req=%b addr=%h want 1/%h", t, mem_req, mem_addr, a); else n_pass++;
            for (int i = 0; i < int'(w); i++) begin
                esc_ir = 1'($urandom_range(0, 1));
                esc_cp = 1'($urandom_range(0, 1)); fonte_cp = 1'($urandom_range(0, 1));
                pc_alvo = 12'($urandom);
                mem_rdata = 16'($urandom);
                tick();
                n_checks++; if (mem_req !== 1'b1 || mem_addr !== a || ir_valido !== 1'b0) $display("FAIL rf_wait%0d: got req=%b addr=%h valid=%b want 1/%h/0", t, mem_req, mem_addr, ir_valido, a); else n_pass++;
            end
            esc_ir = 0; esc_cp = 0;
            mem_ack = 1; mem_rdata = d;
            tick();
            mem_ack = 0;
            n_checks++; if (ir !== d || ir_valido !== 1'b1) $display("FAIL rf_ir%0d: got %h valid=%b want %h/1", t, ir, ir_valido, d); else n_pass++;
            n_checks++; if (opcode !== 4'((d >> 12) & 15) || campo_rd !== 4'((d >> 8) & 15) || campo_rs !== 4'((d >> 4) & 15) || campo_rt !== 4'(d & 15) || imediato !== 8'(d & 255) || endereco !== 12'(d & 4095)) $display("FAIL rf_fields%0d: got %h %h %h %h %h %h for ir %h", t, opcode, campo_rd, campo_rs, campo_rt, imediato, endereco, d); else n_pass++;
            n_checks++; if (pc !== 12'(pcm)) $display("FAIL rf_pc%0d: got %h want %h", t, pc, 12'(pcm)); else n_pass++;
            esc_ir = 1'($urandom_range(0, 1));   // ignored in ENTREGA
            mem_ack = 1;                         // ignored outside BUSCA
            tick();
            esc_ir = 0;
            n_checks++; if (ir_valido !== 1'b0 || ir !== d) $display("FAIL rf_end%0d: got valid=%b ir=%h want 0/%h", t, ir_valido, ir, d); else n_pass++;
            tick();
            mem_ack = 0;
            n_checks++; if (mem_req !== 1'b0 || ocupado !== 1'b0) $display("FAIL rf_idle%0d: got req=%b busy=%b want 0/0", t, mem_req, ocupado); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_fetch();
        set_pc(12'h2A7);
        esc_ir = 1;
        tick();
        esc_ir = 0;
        tick();
        tick();
        rst_n = 0;
        pcm = 0;
        #1;
        n_checks++; if (pc !== 12'h000 || ir !== 16'h0000) $display("FAIL rm_state: got pc=%h ir=%h want 000/0000", pc, ir); else n_pass++;
        n_checks++; if (mem_req !== 1'b0 || ocupado !== 1'b0 || ir_valido !== 1'b0) $display("FAIL rm_flags: got req=%b busy=%b valid=%b want 0/0/0", mem_req, ocupado, ir_valido); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        mem_ack = 1; mem_rdata = 16'hDEAD;
        tick();
        mem_ack = 0;
        n_checks++; if (ir !== 16'h0000 || ir_valido !== 1'b0 || ocupado !== 1'b0) $display("FAIL rm_late_ack: got ir=%h valid=%b busy=%b want 0000/0/0", ir, ir_valido, ocupado); else n_pass++;
    endtask

`ifdef BUSCA_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        set_pc(12'h040);
        esc_ir = 1;
        tick();
        esc_ir = 0;
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_checks++; if (mem_req !== 1'b1 || ir_valido !== 1'b0 || erro_busca !== 1'b0) $display("FAIL to_wait%0d: got req=%b valid=%b err=%b want 1/0/0", c, mem_req, ir_valido, erro_busca); else n_pass++;
        end
        tick();
        n_checks++; if (mem_req !== 1'b0 || ir !== 16'h0000 || ir_valido !== 1'b1 || erro_busca !== 1'b1) $display("FAIL to_abort: got req=%b ir=%h valid=%b err=%b want 0/0000/1/1", mem_req, ir, ir_valido, erro_busca); else n_pass++;
        tick();
        tick();
        n_checks++; if (ir_valido !== 1'b0 || erro_busca !== 1'b1) $display("FAIL to_sticky: got valid=%b err=%b want 0/1", ir_valido, erro_busca); else n_pass++;

        do_reset();
        esc_ir = 1;
        tick();
        esc_ir = 0;
        for (int c = 1; c <= 7; c++) tick();
        mem_ack = 1; mem_rdata = 16'h7E81;
        tick();
        mem_ack = 0;
        n_checks++; if (ir !== 16'h7E81 || ir_valido !== 1'b1 || erro_busca !== 1'b0) $display("FAIL to_ack_wins: got ir=%h valid=%b err=%b want 7e81/1/0", ir, ir_valido, erro_busca); else n_pass++;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait();
        test_waited_fetch();
        test_cond_branch();
        test_wrap();
        test_random_pc();
        test_random_fetch();
        test_reset_mid_fetch();
`ifdef BUSCA_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
